pipeline_hazard_unit: RTL and testbench

//  Parametrised scoreboard + bypass network for the in-order core pipeline; replaces fixed single-stage ALU bypass.

---
 rtl/pipeline_hazard_unit.sv | 113 +++++++++++
 tb/tb_pipeline_hazard_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - scoreboard and bypass network between regfetch and ALU.
// Optional stall/flush statistics counters enabled by PIPELINE_HAZARD_STATS_EN.
module pipeline_hazard_unit #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5,
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3,
  localparam int LATW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid,
  input  logic                     iss_we,
  input  logic [REG_BITS-1:0]      iss_rd,
  input  logic [LATW-1:0]          iss_lat,
  input  logic [NSRC*REG_BITS-1:0] src_idx,
  input  logic [NSRC*XLEN-1:0]     rf_val,
  input  logic [DEPTH*XLEN-1:0]    stg_val,
  input  logic                     flush,
  output logic [NSRC*XLEN-1:0]     src_val,
  output logic                     stall,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              flush_cnt
);

  logic [DEPTH-1:0]    r_v;
  logic [REG_BITS-1:0] r_rd  [DEPTH];
  logic [LATW-1:0]     r_lat [DEPTH];

  logic [DEPTH-1:0] w_ready;
  logic [NSRC-1:0]  w_op_stall;
  logic             w_issue;
  logic             w_stg0_v;

  // Entry k holds a usable result only once it has reached its producing stage.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ready
    assign w_ready[k] = ({1'b0, r_lat[k]} <= (LATW+1)'(k));
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_op
    logic [REG_BITS-1:0] w_idx;
    logic                w_hit;
    logic                w_hit_rdy;
    logic [XLEN-1:0]     w_hit_val;

    assign w_idx = src_idx[i*REG_BITS +: REG_BITS];

    // Scan oldest to youngest so the youngest writer is the last one to land.
    always_comb begin
      w_hit     = 1'b0;
      w_hit_rdy = 1'b0;
      w_hit_val = rf_val[i*XLEN +: XLEN];
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (r_v[k] && (r_rd[k] == w_idx)) begin
          w_hit     = 1'b1;
          w_hit_rdy = w_ready[k];
          w_hit_val = stg_val[k*XLEN +: XLEN];
        end
      end
    end

    assign w_op_stall[i]            = (w_idx != '0) & w_hit & ~w_hit_rdy;
    assign src_val[i*XLEN +: XLEN]  = (w_idx == '0) ? '0 : w_hit_val;
  end

  assign stall    = (|w_op_stall) & ~flush;
  assign w_issue  = iss_valid & ~stall & ~flush;
  assign w_stg0_v = w_issue & iss_we & (iss_rd != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_v <= '0;
    end else begin
      r_v <= {r_v[DEPTH-2:0], w_stg0_v};
    end
    r_rd[0]  <= iss_rd;
    r_lat[0] <= iss_lat;
    for (int k = 1; k < DEPTH; k++) begin
      r_rd[k]  <= r_rd[k-1];
      r_lat[k] <= r_lat[k-1];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && iss_valid) begin
      assert ({1'b0, iss_lat} < (LATW+1)'(DEPTH));
    end
  end
`endif

`ifdef PIPELINE_HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall && iss_valid) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush)              r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb/tb_pipeline_hazard_unit.sv - table-driven bench for pipeline_hazard_unit.
module tb_pipeline_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic        iss_we;
  logic [4:0]  iss_rd;
  logic [1:0]  iss_lat;
  logic [9:0]  src_idx;
  logic [63:0] rf_val;
  logic [95:0] stg_val;
  logic        flush;
  logic [63:0] src_val;
  logic        stall;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_we    (iss_we),
    .iss_rd    (iss_rd),
    .iss_lat   (iss_lat),
    .src_idx   (src_idx),
    .rf_val    (rf_val),
    .stg_val   (stg_val),
    .flush     (flush),
    .src_val   (src_val),
    .stall     (stall),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  typedef struct {
    logic        v;
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  lat;
    logic [4:0]  s0;
    logic [4:0]  s1;
    logic [31:0] rf0;
    logic [31:0] rf1;
    logic [31:0] st0;
    logic [31:0] st1;
    logic [31:0] st2;
    logic        fl;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        est;
    logic        c0;
    logic        c1;
  } vec_t;

  localparam logic [31:0] F0 = 32'hF0F0_0000;
  localparam logic [31:0] F1 = 32'hF1F1_0001;
  localparam logic [31:0] F2 = 32'hF2F2_0002;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic we, logic [4:0] rd, logic [1:0] lat,
                              logic [4:0] s0, logic [4:0] s1,
                              logic [31:0] rf0, logic [31:0] rf1,
                              logic [31:0] st0, logic [31:0] st1, logic [31:0] st2,
                              logic fl, logic [31:0] e0, logic [31:0] e1,
                              logic est, logic c0, logic c1);
    vec_t r;
    r.v = v; r.we = we; r.rd = rd; r.lat = lat; r.s0 = s0; r.s1 = s1;
    r.rf0 = rf0; r.rf1 = rf1; r.st0 = st0; r.st1 = st1; r.st2 = st2;
    r.fl = fl; r.e0 = e0; r.e1 = e1; r.est = est; r.c0 = c0; r.c1 = c1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    iss_valid = t.v;
    iss_we    = t.we;
    iss_rd    = t.rd;
    iss_lat   = t.lat;
    src_idx   = {t.s1, t.s0};
    rf_val    = {t.rf1, t.rf0};
    stg_val   = {t.st2, t.st1, t.st0};
    flush     = t.fl;
  endtask

  initial begin
    logic [31:0] exp_stall_cnt;
    logic [31:0] exp_flush_cnt;

    // Cycle-by-cycle stream: issue fields describe what is presented this cycle.
    vecs.push_back(mk(1,1, 3,0,  7, 0, 32'h70, 32'h55, F0, F1, F2, 0, 32'h70, 0, 0,1,1));
    vecs.push_back(mk(1,1, 4,1,  3, 0, 32'h30, 32'h55, 32'h11, 32'h99, 32'h98, 0, 32'h11, 0, 0,1,1));
    vecs.push_back(mk(1,1, 8,0,  4, 3, 32'h40, 32'h30, 32'h44, 32'h11, F2, 0, 0, 32'h11, 1,0,1));
    vecs.push_back(mk(1,1, 8,0,  4, 3, 32'h40, 32'h30, 32'h44, 32'hAB, 32'h11, 0, 32'hAB, 32'h11, 0,1,1));
    vecs.push_back(mk(1,1, 5,0,  4, 8, 32'h40, 32'h80, 32'h88, F1, 32'hAB, 0, 32'hAB, 32'h88, 0,1,1));
    vecs.push_back(mk(1,1, 5,0,  5, 8, 32'h50, 32'h80, 32'h55, 32'h88, F2, 0, 32'h55, 32'h88, 0,1,1));
    vecs.push_back(mk(0,0, 0,0,  5, 8, 32'h50, 32'h80, 32'h33, 32'h44, 32'h22, 0, 32'h33, 32'h22, 0,1,1));
    vecs.push_back(mk(1,1, 9,0,  5, 0, 32'h50, 0, F0, 32'h66, 32'h22, 0, 32'h66, 0, 0,1,1));
    vecs.push_back(mk(1,1, 9,1,  9, 5, 32'h90, 32'h50, 32'h91, F1, 32'h77, 0, 32'h91, 32'h77, 0,1,1));
    vecs.push_back(mk(1,1, 0,0,  9, 0, 32'h90, 0, F0, F1, F2, 0, 0, 0, 1,0,1));
    vecs.push_back(mk(1,1, 0,0,  9, 0, 32'h90, 32'hFFFF, F0, 32'hA9, F2, 0, 32'hA9, 0, 0,1,1));
    vecs.push_back(mk(1,1, 6,1,  0, 9, 32'hFFFF, 32'h90, F0, F1, 32'hB9, 0, 0, 32'hB9, 0,1,1));
    vecs.push_back(mk(1,1, 7,0,  6, 0, 32'h60, 0, F0, F1, F2, 1, 0, 0, 0,0,1));
    vecs.push_back(mk(1,1,10,2,  6, 7, 32'h600, 32'h700, F0, F1, F2, 0, 32'h600, 32'h700, 0,1,1));
    vecs.push_back(mk(0,0, 0,0, 10, 0, 32'h100, 0, F0, F1, F2, 0, 0, 0, 1,0,1));
    vecs.push_back(mk(1,1,11,0, 10, 0, 32'h100, 0, F0, F1, F2, 0, 0, 0, 1,0,1));
    vecs.push_back(mk(0,0, 0,0, 10, 0, 32'h100, 0, F0, F1, 32'h10A, 0, 32'h10A, 0, 0,1,1));

    rst = 1'b1;
    drive(mk(0,0,0,0, 5, 0, 32'h1234, 32'hFFFF, F0, F1, F2, 0, 0,0,0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_src0",  src_val[31:0],  32'h1234);
    check("reset_src1",  src_val[63:32], 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);
    check("reset_stall_cnt", stall_cnt,  32'h0);
    check("reset_flush_cnt", flush_cnt,  32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      drive(vecs[r]);
      @(negedge clk);
      check($sformatf("row%0d_stall", r), {31'b0, stall}, {31'b0, vecs[r].est});
      if (vecs[r].c0) check($sformatf("row%0d_src0", r), src_val[31:0],  vecs[r].e0);
      if (vecs[r].c1) check($sformatf("row%0d_src1", r), src_val[63:32], vecs[r].e1);
      @(posedge clk);
      #1;
    end

`ifdef PIPELINE_HAZARD_STATS_EN
    exp_stall_cnt = 32'd3;
    exp_flush_cnt = 32'd1;
`else
    exp_stall_cnt = 32'd0;
    exp_flush_cnt = 32'd0;
`endif
    drive(mk(0,0,0,0, 0, 0, 0, 0, F0, F1, F2, 0, 0,0,0,0,0));
    @(negedge clk);
    check("stall_cnt", stall_cnt, exp_stall_cnt);
    check("flush_cnt", flush_cnt, exp_flush_cnt);

    // Reset mid-stream: a live r12 writer must vanish.
    @(posedge clk);
    #1 drive(mk(1,1,12,0, 0, 0, 0, 0, F0, F1, F2, 0, 0,0,0,0,0));
    @(posedge clk);
    #1 rst = 1'b1;
    drive(mk(0,0,0,0, 12, 0, 32'h1200, 0, 32'hC0C0, F1, F2, 0, 0,0,0,0,0));
    @(negedge clk);
    check("pre_reset_fwd", src_val[31:0], 32'hC0C0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_src0",  src_val[31:0], 32'h1200);
    check("post_reset_stall", {31'b0, stall}, 32'h0);
    check("post_reset_stall_cnt", stall_cnt, 32'h0);
    check("post_reset_flush_cnt", flush_cnt, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
